// File: rtl/mem_issue_arbiter_pkg.sv
// Shared types and constants for the memory issue arbiter and its round-robin picker.
package mem_issue_arbiter_pkg;

    localparam int unsigned MEM_ARB_MAX_REQ = 4;
    localparam int unsigned ROB_IDX_W       = 6;
    localparam int unsigned MEM_ADDR_W      = 32;
    localparam int unsigned MEM_DATA_W      = 32;
    localparam int unsigned MEM_SIZE_W      = 2;

    typedef enum logic {
        MEM_ARB_ARB,
        MEM_ARB_LOCK
    } MemArbState;

    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] rob_idx;
    } MemBaseSt;

    typedef struct packed {
        logic                  atomic_op;
        logic                  is_store;
        logic [MEM_SIZE_W-1:0] size;
    } MemOcSt;

    typedef struct packed {
        MemBaseSt              base;
        MemOcSt                mem_oc;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] data;
    } MemExeSt;

    // Pointer width for an n-way round-robin; never narrower than one bit.
    function automatic int unsigned rr_ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set valid bit at or after ptr_i, wrapping at NUM_REQ.
module rr_picker #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]   idx_o
);

    localparam int unsigned SUM_W = PTR_W + 1;

    logic [SUM_W-1:0] sum;
    logic [PTR_W-1:0] cand;
    logic             found;

    // Walk ptr, ptr+1, ... modulo NUM_REQ; the first hit wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_i} + SUM_W'(k);
            if (sum >= SUM_W'(NUM_REQ)) begin
                sum = sum - SUM_W'(NUM_REQ);
            end
            cand = sum[PTR_W-1:0];
            if (!found && valid_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/mem_issue_arbiter.sv
// Round-robin arbiter onto the single memory exe port, with a one-deep output stage and an LL/SC lock.
// Optional performance counters are built when MEM_ARB_PERF_EN is defined.
module mem_issue_arbiter
    import mem_issue_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  MemExeSt            req_i [NUM_REQ],
    output logic [NUM_REQ-1:0] req_ready_o,
    output MemExeSt            exe_o,
    input  logic               exe_ready_i,
    input  logic               atomic_done_i
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]        perf_grant_cnt_o,
    output logic [31:0]        perf_lock_cyc_o
`endif
);

    localparam int unsigned PTR_W = rr_ptr_width(NUM_REQ);

    if ((NUM_REQ < 2) || (NUM_REQ > MEM_ARB_MAX_REQ)) begin : g_bad_num_req
        $error("mem_issue_arbiter: NUM_REQ must be in 2..%0d", MEM_ARB_MAX_REQ);
    end

    MemArbState         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    MemExeSt            exe_q, exe_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic [PTR_W-1:0]   pick_idx;
    logic               out_free;
    logic               grant_en;
    logic               grant;
    MemExeSt            sel_req;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .valid_i (req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx)
    );

    // A grant needs a free output slot, no outstanding atomic, and no flush/reset this cycle.
    always_comb begin
        out_free    = ~exe_q.base.valid | exe_ready_i;
        grant_en    = (state_q == MEM_ARB_ARB) & out_free & ~flush_i & ~rst;
        grant       = grant_en & (|pick_grant);
        sel_req     = req_i[pick_idx];
        req_ready_o = grant_en ? pick_grant : '0;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        exe_d   = exe_q;

        case (state_q)
            MEM_ARB_ARB: begin
                if (grant && sel_req.mem_oc.atomic_op) begin
                    state_d = MEM_ARB_LOCK;
                end
            end
            MEM_ARB_LOCK: begin
                if (atomic_done_i) begin
                    state_d = MEM_ARB_ARB;
                end
            end
            default: state_d = MEM_ARB_ARB;
        endcase

        if (grant) begin
            exe_d = sel_req;
            ptr_d = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
        end else if (exe_ready_i) begin
            exe_d.base.valid = 1'b0;
        end

        // Flush kills the staged op and any lock but keeps the fairness pointer.
        if (flush_i) begin
            exe_d.base.valid = 1'b0;
            state_d          = MEM_ARB_ARB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MEM_ARB_ARB;
            ptr_q   <= '0;
            exe_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            exe_q   <= exe_d;
        end
    end

    assign exe_o = exe_q;

`ifdef MEM_ARB_PERF_EN
    localparam int unsigned PERF_W = 32;

    logic [PERF_W-1:0] grant_cnt_q, grant_cnt_d;
    logic [PERF_W-1:0] lock_cyc_q, lock_cyc_d;

    // Free-running wrap-around counters; flush does not clear them.
    always_comb begin
        grant_cnt_d = grant_cnt_q + PERF_W'(grant);
        lock_cyc_d  = lock_cyc_q + PERF_W'(state_q == MEM_ARB_LOCK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt_q <= '0;
            lock_cyc_q  <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            lock_cyc_q  <= lock_cyc_d;
        end
    end

    assign perf_grant_cnt_o = grant_cnt_q;
    assign perf_lock_cyc_o  = lock_cyc_q;
`endif

endmodule

// File: doc/mem_issue_arbiter.md
# mem_issue_arbiter

Round-robin arbiter sharing the single memory-pipeline exe port among up to four memory issue queues. Sits between the memory issue queues and the memory block's `exe_i`/`exe_ready_o` handshake. Registers the selected `MemExeSt` into one output stage. Holds off all further grants while an atomic (LL/SC) operation is outstanding, until its write-back completes.

## Interface
- `NUM_REQ`, default 2: number of requesters, legal range 2..4.
- `clk  in  1`: clock.
- `rst  in  1`: reset, synchronous, active-high. One clock domain.
- `flush_i  in  1`: pipeline flush.
- `req_valid_i  in  NUM_REQ`: per-requester valid.
- `req_i  in  NUM_REQ x MemExeSt`: per-requester payload.
- `req_ready_o  out  NUM_REQ`: per-requester accept; one-hot or zero.
- `exe_o  out  MemExeSt`: registered payload to the memory block. `exe_o.base.valid` is the output valid.
- `exe_ready_i  in  1`: memory block ready.
- `atomic_done_i  in  1`: write-back of an atomic op accepted, i.e. `wb.base.valid & wb.atomic & wb_ready`.
- `perf_grant_cnt_o  out  32`: present only with `MEM_ARB_PERF_EN`.
- `perf_lock_cyc_o  out  32`: present only with `MEM_ARB_PERF_EN`.

## Operation
- `out_free = ~exe_o.base.valid | exe_ready_i`.
- State machine, `MemArbState`:
  - ARB → LOCK: an accepted grant has `req_i[g].mem_oc.atomic_op = 1`.
  - LOCK → ARB: `atomic_done_i = 1`.
  - `atomic_done_i` in ARB: ignored.
- Grant:
  - Only in ARB with `out_free = 1`.
  - Candidate `g` = first `i` with `req_valid_i[i]`, searching `ptr, ptr+1, …` mod `NUM_REQ`.
  - `req_ready_o[g] = 1`; all others 0.
  - A `req_valid_i[i]` whose payload has `base.valid = 0` still arbitrates and is passed through unchanged.
- Pointer `ptr`, width `$clog2(NUM_REQ)`:
  - After a grant to `g`, `ptr <= (g+1 == NUM_REQ) ? 0 : g+1`.
  - Unchanged when there is no grant.
- Output register:
  - On grant: `exe_o <= req_i[g]`.
  - No grant and `exe_ready_i = 1`: `exe_o.base.valid <= 0`.
  - Otherwise `exe_o` holds.
- LOCK:
  - No grants; all `req_ready_o = 0`.
  - The output register still drains normally, so the atomic op itself is delivered.
- Flush:
  - Takes precedence over every other event in that cycle: `exe_o.base.valid <= 0`, state `<=` ARB.
  - `ptr` is kept.
  - `req_ready_o` is forced to 0 during the flush cycle.
- Reset: `exe_o <= '0`, `ptr <= 0`, state `<=` ARB, perf counters `<= 0`. `req_ready_o = 0` while `rst = 1`.

## Timing
- Accept at edge N → `exe_o` valid during cycle N+1.
- Full throughput: one grant per cycle while `exe_ready_i = 1` in ARB.
- `req_ready_o` is combinational from `req_valid_i`, `ptr`, state, `exe_o.base.valid`, `exe_ready_i`, `flush_i`, `rst`. Requesters must not make `req_valid_i` depend on `req_ready_o`.
- An atomic accepted at edge N: state is LOCK from cycle N+1.
- `atomic_done_i` at edge M: grants resume in cycle M+1.
- Back-pressure: a held output (`exe_ready_i = 0`) blocks new grants. The payload in `exe_o` must stay stable until it is accepted.

## Configuration
- `MEM_ARB_PERF_EN` defined:
  - `perf_grant_cnt_o` increments on every grant.
  - `perf_lock_cyc_o` increments on every cycle in LOCK.
  - Both wrap at 2^32, are cleared by reset, and are not cleared by flush.
- `MEM_ARB_PERF_EN` undefined: both ports and both counters are absent; behaviour is otherwise identical.

## Structure
- In `Pipeline.svh`:
  - `typedef enum logic {MEM_ARB_ARB, MEM_ARB_LOCK} MemArbState`.
  - Constant `MEM_ARB_MAX_REQ = 4`.
- Sub-module `rr_picker`, purely combinational:
  - Inputs: `NUM_REQ`-bit valid vector and `ptr`.
  - Outputs: one-hot grant and encoded index.
  - Reused for any later round-robin arbiters.
- The top level holds the FSM, `ptr`, the output register and the optional perf counters; target ~150–250 lines.

## Test plan
- NUM_REQ=2, both valid every cycle, `exe_ready_i = 1`, no atomics → grants alternate 0,1,0,1; `exe_o.base.rob_idx` follows one cycle later; `perf_grant_cnt_o = 8` after 8 cycles.
- Req1 issues an atomic LL; req0 stays valid → LL on `exe_o` next cycle, then no `req_ready_o` for 5 cycles; `atomic_done_i` pulses at cycle 6 → req0 granted in cycle 7; `perf_lock_cyc_o = 6`.
- `exe_ready_i = 0` for 3 cycles with `exe_o` valid → `exe_o` stable, all `req_ready_o = 0`; release → next grant in the same cycle.
- `flush_i` asserted while in LOCK with `exe_o` valid → next cycle `exe_o.base.valid = 0`, state ARB, `ptr` unchanged, grant resumes the cycle after the flush.
- NUM_REQ=3, only req2 valid with `ptr = 0` → req2 granted; `ptr` becomes 0; then req0 and req2 both valid → req0 granted first.
- `rst` asserted mid-stream with atomic in flight → next cycle `exe_o = '0`, ARB, `ptr = 0`, counters 0.
